// File: rtl/usb_hub_pkg.sv
// Shared definitions for the USB hub repeater controller: line-state codes and
// the controller state encoding exposed on ctrl_state.
package usb_hub_pkg;

  localparam logic [1:0] LINE_SE0 = 2'b00;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_SE1 = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_DOWN        = 3'd1,
    ST_UP          = 3'd2,
    ST_EOP_J       = 3'd3,
    ST_BABBLE_WAIT = 3'd4
  } ctrl_state_e;

endpackage

// File: rtl/usb_eop_detect.sv
// Watches the currently selected source line: qualifies end-of-packet (long SE0
// followed by J) and reports when J has been held for a full bit time.
module usb_eop_detect
  import usb_hub_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [1:0] line,
  output logic       eop,
  output logic       j_run_done
);

  localparam int SE0_MIN = 2 * CLKS_PER_BIT;
  localparam int SE0_W   = $clog2(SE0_MIN + 1);
  localparam int J_W     = $clog2(CLKS_PER_BIT + 1);

  logic [SE0_W-1:0] se0_cnt;
  logic [J_W-1:0]   j_cnt;

  // Both counters hold the run length of the cycles before the current one;
  // they restart whenever the controller is not watching a source line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      se0_cnt <= '0;
      j_cnt   <= '0;
    end else if (!run) begin
      se0_cnt <= '0;
      j_cnt   <= '0;
    end else begin
      if (line == LINE_SE0) begin
        if (se0_cnt != '1) se0_cnt <= se0_cnt + SE0_W'(1);
      end else begin
        se0_cnt <= '0;
      end
      if (line == LINE_J) begin
        if (j_cnt != '1) j_cnt <= j_cnt + J_W'(1);
      end else begin
        j_cnt <= '0;
      end
    end
  end

  assign eop        = run && (line == LINE_J) && (se0_cnt >= SE0_W'(SE0_MIN));
  assign j_run_done = run && (line == LINE_J) && (j_cnt >= J_W'(CLKS_PER_BIT - 1));

endmodule

// File: rtl/usb_hub_repeater_ctrl.sv
// Full-speed hub repeater direction controller: picks the packet source on SOP,
// steers drive enables, generates the EOP J hold and isolates babbling ports.
module usb_hub_repeater_ctrl
  import usb_hub_pkg::*;
#(
  parameter int NUM_USB_DEVICES = 2,
  parameter int CLKS_PER_BIT    = 4,
  parameter int MAX_PKT_CLKS    = 36000,
  localparam int DEV_IDX_W      = (NUM_USB_DEVICES > 1) ? $clog2(NUM_USB_DEVICES) : 1
) (
  input  logic                         hi_clock,
  input  logic                         hi_reset_n,
  input  logic [NUM_USB_DEVICES-1:0]   port_enable,
  input  logic [1:0]                   host_line,
  input  logic [2*NUM_USB_DEVICES-1:0] dev_line,
  output logic                         dir_up,
  output logic [DEV_IDX_W-1:0]         dev_sel,
  output logic                         host_drive_en,
  output logic [NUM_USB_DEVICES-1:0]   dev_drive_en,
  output logic [NUM_USB_DEVICES-1:0]   babble_err,
  output logic                         busy,
  output logic [2:0]                   ctrl_state
);

  localparam int LEN_W = $clog2(MAX_PKT_CLKS + 1);
  localparam int EOP_W = $clog2(CLKS_PER_BIT + 1);

  ctrl_state_e                state;
  logic [LEN_W-1:0]           len_cnt;
  logic [EOP_W-1:0]           eop_cnt;
  logic [NUM_USB_DEVICES-1:0] eligible;
  logic                       up_hit;
  logic [DEV_IDX_W-1:0]       up_sel;
  logic [1:0]                 sel_line;
  logic [1:0]                 src_line;
  logic                       sel_en;
  logic                       det_run;
  logic                       eop;
  logic                       j_run_done;
  logic                       leave;

  always_comb begin
    eligible = port_enable & ~babble_err;
    up_hit   = 1'b0;
    up_sel   = '0;
    sel_line = LINE_J;
    sel_en   = 1'b0;
    // Descending scan so the lowest-numbered port showing K wins.
    for (int i = NUM_USB_DEVICES - 1; i >= 0; i--) begin
      if (eligible[i] && (dev_line[2*i +: 2] == LINE_K)) begin
        up_hit = 1'b1;
        up_sel = DEV_IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_USB_DEVICES; i++) begin
      if (DEV_IDX_W'(i) == dev_sel) begin
        sel_line = dev_line[2*i +: 2];
        sel_en   = port_enable[i];
      end
    end
    src_line = (state == ST_DOWN) ? host_line : sel_line;
    det_run  = (state == ST_DOWN) || (state == ST_UP) || (state == ST_BABBLE_WAIT);
    // Losing the upstream source port abandons the transfer outright.
    leave = (!sel_en && ((state == ST_UP) || (state == ST_BABBLE_WAIT) ||
                         ((state == ST_EOP_J) && dir_up))) ||
            ((state == ST_EOP_J) && (eop_cnt == EOP_W'(CLKS_PER_BIT - 1))) ||
            ((state == ST_BABBLE_WAIT) && j_run_done);
  end

  usb_eop_detect #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_eop_detect (
    .clk       (hi_clock),
    .rst_n     (hi_reset_n),
    .run       (det_run),
    .line      (src_line),
    .eop       (eop),
    .j_run_done(j_run_done)
  );

  always_ff @(posedge hi_clock or negedge hi_reset_n) begin
    if (!hi_reset_n) begin
      state         <= ST_IDLE;
      dir_up        <= 1'b0;
      dev_sel       <= '0;
      host_drive_en <= 1'b0;
      dev_drive_en  <= '0;
      babble_err    <= '0;
      busy          <= 1'b0;
      len_cnt       <= '0;
      eop_cnt       <= '0;
    end else begin
      for (int i = 0; i < NUM_USB_DEVICES; i++) begin
        if (!port_enable[i]) babble_err[i] <= 1'b0;
      end
      if (leave) begin
        state         <= ST_IDLE;
        busy          <= 1'b0;
        dir_up        <= 1'b0;
        host_drive_en <= 1'b0;
        dev_drive_en  <= '0;
        len_cnt       <= '0;
        eop_cnt       <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            len_cnt <= '0;
            eop_cnt <= '0;
            if (host_line == LINE_K) begin
              state         <= ST_DOWN;
              busy          <= 1'b1;
              dir_up        <= 1'b0;
              host_drive_en <= 1'b0;
              dev_drive_en  <= eligible;
            end else if (up_hit) begin
              state         <= ST_UP;
              busy          <= 1'b1;
              dir_up        <= 1'b1;
              dev_sel       <= up_sel;
              host_drive_en <= 1'b1;
              dev_drive_en  <= '0;
            end
          end
          ST_DOWN: begin
            dev_drive_en <= eligible;
            if (eop) state <= ST_EOP_J;
          end
          ST_UP: begin
            if (eop) begin
              state <= ST_EOP_J;
            end else if (len_cnt == LEN_W'(MAX_PKT_CLKS - 1)) begin
              state         <= ST_BABBLE_WAIT;
              host_drive_en <= 1'b0;
              for (int i = 0; i < NUM_USB_DEVICES; i++) begin
                if (DEV_IDX_W'(i) == dev_sel) babble_err[i] <= 1'b1;
              end
            end else begin
              len_cnt <= len_cnt + LEN_W'(1);
            end
          end
          ST_EOP_J: begin
            eop_cnt <= eop_cnt + EOP_W'(1);
          end
          ST_BABBLE_WAIT: begin
            state <= ST_BABBLE_WAIT;
          end
          default: begin
            state         <= ST_IDLE;
            busy          <= 1'b0;
            dir_up        <= 1'b0;
            host_drive_en <= 1'b0;
            dev_drive_en  <= '0;
          end
        endcase
      end
    end
  end

  assign ctrl_state = state;

endmodule

// File: tb/tb_usb_hub_repeater_ctrl.sv
// Self-checking bench for usb_hub_repeater_ctrl with 2 ports, 4 clocks/bit and a
// 64-cycle babble limit; directed scenarios plus randomized back-to-back packets.
module tb_usb_hub_repeater_ctrl;
  import usb_hub_pkg::*;

  localparam int N    = 2;
  localparam int CPB  = 4;
  localparam int MAXP = 64;

  logic           hi_clock = 1'b0;
  logic           hi_reset_n;
  logic [N-1:0]   port_enable;
  logic [1:0]     host_line;
  logic [2*N-1:0] dev_line;
  logic           dir_up;
  logic [0:0]     dev_sel;
  logic           host_drive_en;
  logic [N-1:0]   dev_drive_en;
  logic [N-1:0]   babble_err;
  logic           busy;
  logic [2:0]     ctrl_state;

  int vectors     = 0;
  int miscompares = 0;

  usb_hub_repeater_ctrl #(
    .NUM_USB_DEVICES(N),
    .CLKS_PER_BIT   (CPB),
    .MAX_PKT_CLKS   (MAXP)
  ) dut (
    .hi_clock     (hi_clock),
    .hi_reset_n   (hi_reset_n),
    .port_enable  (port_enable),
    .host_line    (host_line),
    .dev_line     (dev_line),
    .dir_up       (dir_up),
    .dev_sel      (dev_sel),
    .host_drive_en(host_drive_en),
    .dev_drive_en (dev_drive_en),
    .babble_err   (babble_err),
    .busy         (busy),
    .ctrl_state   (ctrl_state)
  );

  always #5 hi_clock = ~hi_clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge hi_clock);
    #1;
  endtask

  task automatic set_src(input logic up, input int port, input logic [1:0] v);
    if (up) dev_line[2*port +: 2] = v;
    else    host_line = v;
  endtask

  function automatic logic [1:0] rand_sym();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0)     return LINE_SE1;
    else if (r < 4) return LINE_J;
    else            return LINE_K;
  endfunction

  // Long SE0 then J; the J hold lasts CPB cycles before the return to idle.
  task automatic finish_packet(input logic up, input int port);
    int n;
    for (int i = 0; i < 2*CPB; i++) begin
      set_src(up, port, LINE_SE0);
      step();
    end
    set_src(up, port, LINE_J);
    n = 0;
    do begin
      step();
      n++;
    end while (ctrl_state !== ST_IDLE && n < 20);
    vectors++;
    if (n != CPB + 1) begin
      miscompares++;
      $display("FAIL eop_to_idle: got %0d cycles, want %0d", n, CPB + 1);
    end
  endtask

  task automatic test_reset();
    hi_reset_n  = 1'b0;
    port_enable = 2'b11;
    host_line   = LINE_J;
    dev_line    = {LINE_J, LINE_J};
    step();
    step();
    vectors++;
    if ({ctrl_state, dir_up, dev_sel, host_drive_en, dev_drive_en, babble_err, busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: state=%0d dir=%b sel=%0d hde=%b dde=%b bab=%b busy=%b, want all 0",
               ctrl_state, dir_up, dev_sel, host_drive_en, dev_drive_en, babble_err, busy);
    end
    hi_reset_n = 1'b1;
    step();
    vectors++;
    if (ctrl_state !== ST_IDLE || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: state=%0d busy=%b, want %0d 0", ctrl_state, busy, ST_IDLE);
    end
  endtask

  task automatic test_downstream();
    host_line = LINE_K;
    step();
    vectors++;
    if (ctrl_state !== ST_DOWN || dev_drive_en !== 2'b11 || host_drive_en !== 1'b0 ||
        dir_up !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL down_entry: state=%0d dde=%b hde=%b dir=%b busy=%b, want %0d 11 0 0 1",
               ctrl_state, dev_drive_en, host_drive_en, dir_up, busy, ST_DOWN);
    end
    for (int i = 1; i < 40 + 2*CPB; i++) begin
      host_line = (i >= 40) ? LINE_SE0 : ($urandom_range(0, 1) ? LINE_K : LINE_J);
      step();
      vectors++;
      if (ctrl_state !== ST_DOWN || dev_drive_en !== 2'b11) begin
        miscompares++;
        $display("FAIL down_body[%0d]: state=%0d dde=%b, want %0d 11", i, ctrl_state, dev_drive_en, ST_DOWN);
      end
    end
    host_line = LINE_J;
    for (int i = 0; i < CPB; i++) begin
      step();
      vectors++;
      if (ctrl_state !== ST_EOP_J || dev_drive_en !== 2'b11) begin
        miscompares++;
        $display("FAIL down_eop_j[%0d]: state=%0d dde=%b, want %0d 11", i, ctrl_state, dev_drive_en, ST_EOP_J);
      end
    end
    step();
    vectors++;
    if (ctrl_state !== ST_IDLE || dev_drive_en !== 2'b00 || host_drive_en !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL down_idle: state=%0d dde=%b hde=%b busy=%b, want %0d 00 0 0",
               ctrl_state, dev_drive_en, host_drive_en, busy, ST_IDLE);
    end
  endtask

  task automatic test_host_priority();
    host_line = LINE_K;
    dev_line  = {LINE_K, LINE_J};
    step();
    vectors++;
    if (ctrl_state !== ST_DOWN || dir_up !== 1'b0) begin
      miscompares++;
      $display("FAIL host_wins: state=%0d dir=%b, want %0d 0", ctrl_state, dir_up, ST_DOWN);
    end
    dev_line = {LINE_J, LINE_J};
    finish_packet(1'b0, 0);
    dev_line = {LINE_K, LINE_K};
    step();
    vectors++;
    if (ctrl_state !== ST_UP || dev_sel !== 1'b0 || dir_up !== 1'b1 ||
        host_drive_en !== 1'b1 || dev_drive_en !== 2'b00) begin
      miscompares++;
      $display("FAIL lowest_port: state=%0d sel=%0d dir=%b hde=%b dde=%b, want %0d 0 1 1 00",
               ctrl_state, dev_sel, dir_up, host_drive_en, dev_drive_en, ST_UP);
    end
    dev_line[3:2] = LINE_J;
    finish_packet(1'b1, 0);
  endtask

  task automatic test_short_se0();
    dev_line[1:0] = LINE_K;
    step();
    for (int i = 0; i < 3; i++) begin
      dev_line[1:0] = $urandom_range(0, 1) ? LINE_K : LINE_J;
      step();
    end
    for (int i = 0; i < 5; i++) begin
      dev_line[1:0] = LINE_SE0;
      step();
    end
    dev_line[1:0] = LINE_K;
    step();
    vectors++;
    if (ctrl_state !== ST_UP || host_drive_en !== 1'b1) begin
      miscompares++;
      $display("FAIL short_se0: state=%0d hde=%b, want %0d 1", ctrl_state, host_drive_en, ST_UP);
    end
    for (int i = 0; i < 2*CPB; i++) begin
      dev_line[1:0] = LINE_SE0;
      step();
    end
    dev_line[1:0] = LINE_J;
    step();
    vectors++;
    if (ctrl_state !== ST_EOP_J || host_drive_en !== 1'b1) begin
      miscompares++;
      $display("FAIL long_se0_eop: state=%0d hde=%b, want %0d 1", ctrl_state, host_drive_en, ST_EOP_J);
    end
    for (int i = 0; i < CPB; i++) step();
    vectors++;
    if (ctrl_state !== ST_IDLE || host_drive_en !== 1'b0) begin
      miscompares++;
      $display("FAIL up_eop_idle: state=%0d hde=%b, want %0d 0", ctrl_state, host_drive_en, ST_IDLE);
    end
  endtask

  task automatic test_babble();
    int n;
    dev_line[3:2] = LINE_K;
    step();
    vectors++;
    if (ctrl_state !== ST_UP || dev_sel !== 1'b1) begin
      miscompares++;
      $display("FAIL babble_entry: state=%0d sel=%0d, want %0d 1", ctrl_state, dev_sel, ST_UP);
    end
    n = 1;
    while (n < 200) begin
      step();
      if (ctrl_state !== ST_UP) break;
      n++;
    end
    vectors++;
    if (n != MAXP) begin
      miscompares++;
      $display("FAIL babble_len: got %0d cycles in UP, want %0d", n, MAXP);
    end
    vectors++;
    if (ctrl_state !== ST_BABBLE_WAIT || babble_err !== 2'b10 || host_drive_en !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL babble_flag: state=%0d bab=%b hde=%b busy=%b, want %0d 10 0 1",
               ctrl_state, babble_err, host_drive_en, busy, ST_BABBLE_WAIT);
    end
    dev_line[3:2] = LINE_J;
    for (int i = 0; i < CPB; i++) begin
      step();
      vectors++;
      if (ctrl_state !== ((i == CPB - 1) ? ST_IDLE : ST_BABBLE_WAIT)) begin
        miscompares++;
        $display("FAIL babble_j_run[%0d]: state=%0d, want %0d", i, ctrl_state,
                 (i == CPB - 1) ? ST_IDLE : ST_BABBLE_WAIT);
      end
    end
    dev_line[3:2] = LINE_K;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (ctrl_state !== ST_IDLE || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL babble_ignored[%0d]: state=%0d busy=%b, want %0d 0", i, ctrl_state, busy, ST_IDLE);
      end
    end
    dev_line[3:2]  = LINE_J;
    port_enable[1] = 1'b0;
    step();
    vectors++;
    if (babble_err !== 2'b00) begin
      miscompares++;
      $display("FAIL babble_clear: bab=%b, want 00", babble_err);
    end
    port_enable[1] = 1'b1;
    dev_line[3:2]  = LINE_K;
    step();
    vectors++;
    if (ctrl_state !== ST_UP || dev_sel !== 1'b1) begin
      miscompares++;
      $display("FAIL babble_reenabled: state=%0d sel=%0d, want %0d 1", ctrl_state, dev_sel, ST_UP);
    end
    finish_packet(1'b1, 1);
  endtask

  task automatic test_reset_mid();
    dev_line[1:0] = LINE_K;
    step();
    dev_line[1:0] = LINE_J;
    step();
    dev_line[1:0] = LINE_K;
    #2;
    hi_reset_n = 1'b0;
    #1;
    vectors++;
    if ({ctrl_state, dir_up, dev_sel, host_drive_en, dev_drive_en, babble_err, busy} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: state=%0d dir=%b sel=%0d hde=%b dde=%b bab=%b busy=%b, want all 0",
               ctrl_state, dir_up, dev_sel, host_drive_en, dev_drive_en, babble_err, busy);
    end
    dev_line = {LINE_J, LINE_J};
    step();
    hi_reset_n = 1'b1;
    step();
    vectors++;
    if (ctrl_state !== ST_IDLE || host_drive_en !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_no_eop: state=%0d hde=%b busy=%b, want %0d 0 0",
               ctrl_state, host_drive_en, busy, ST_IDLE);
    end
  endtask

  task automatic test_enable_drop();
    dev_line[1:0] = LINE_K;
    step();
    for (int i = 0; i < 4; i++) begin
      dev_line[1:0] = $urandom_range(0, 1) ? LINE_K : LINE_J;
      step();
    end
    port_enable[0] = 1'b0;
    step();
    vectors++;
    if (ctrl_state !== ST_IDLE || host_drive_en !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL enable_drop: state=%0d hde=%b busy=%b, want %0d 0 0",
               ctrl_state, host_drive_en, busy, ST_IDLE);
    end
    port_enable   = 2'b11;
    dev_line[1:0] = LINE_J;
    step();
  endtask

  // Random packets launched the cycle after idle is reached. The generator
  // knows where its terminating J sits, so expected timing follows directly.
  task automatic test_back_to_back();
    logic [1:0]  seq[$];
    logic        up;
    int          port;
    int          e;
    logic [N-1:0] mask;
    ctrl_state_e exp_st;
    logic        exp_h;
    logic [N-1:0] exp_d;
    for (int p = 0; p < 16; p++) begin
      up   = 1'($urandom_range(0, 1));
      port = $urandom_range(0, N - 1);
      mask = N'($urandom_range(0, (1 << N) - 1));
      if (up) mask[port] = 1'b1;
      port_enable = mask;
      seq.delete();
      seq.push_back(LINE_K);
      for (int i = 0; i < $urandom_range(2, 20); i++) seq.push_back(rand_sym());
      if ($urandom_range(0, 1)) begin
        for (int i = 0; i < $urandom_range(1, 2*CPB - 1); i++) seq.push_back(LINE_SE0);
        seq.push_back(LINE_K);
      end
      for (int i = 0; i < $urandom_range(2*CPB, 2*CPB + 4); i++) seq.push_back(LINE_SE0);
      seq.push_back(LINE_J);
      e = seq.size() - 1;
      for (int k = 0; k <= e + CPB; k++) begin
        set_src(up, port, (k <= e) ? seq[k] : LINE_J);
        step();
        if (k < e)            exp_st = up ? ST_UP : ST_DOWN;
        else if (k < e + CPB) exp_st = ST_EOP_J;
        else                  exp_st = ST_IDLE;
        exp_h = (exp_st != ST_IDLE) && up;
        exp_d = ((exp_st != ST_IDLE) && !up) ? mask : '0;
        vectors++;
        if (ctrl_state !== exp_st || host_drive_en !== exp_h || dev_drive_en !== exp_d ||
            busy !== (exp_st != ST_IDLE) || (exp_h && dev_sel !== 1'(port))) begin
          miscompares++;
          $display("FAIL pkt%0d_cyc%0d: state=%0d hde=%b dde=%b busy=%b sel=%0d, want %0d %b %b %b %0d",
                   p, k, ctrl_state, host_drive_en, dev_drive_en, busy, dev_sel,
                   exp_st, exp_h, exp_d, exp_st != ST_IDLE, port);
        end
      end
    end
    port_enable = 2'b11;
  endtask

  initial begin
    test_reset();
    test_downstream();
    test_host_priority();
    test_short_se0();
    test_babble();
    test_reset_mid();
    test_enable_drop();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
